// File: rtl/spi_pkg.sv
// spi_pkg: shared SPI master constants and FSM state encoding
package spi_pkg;
  localparam int DATA_W  = 8;
  localparam int NCS     = 4;
  localparam int CS_W    = $clog2(NCS);
  localparam int N_EDGES = 2 * DATA_W;
  localparam int EDGE_W  = $clog2(N_EDGES + 1);
  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;
endpackage

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period down-counter emitting a one-cycle half_tick strobe
module spi_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_half_tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TOP = CW'(CLK_DIV - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    if (rst || i_clr) r_cnt <= TOP;
    else r_cnt <= (r_cnt == '0) ? TOP : r_cnt - 1'b1;
  assign o_half_tick = (r_cnt == '0) && !i_clr;
endmodule

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI master sequencer driving SCLK/MOSI/CS and capturing MISO
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_en,
  input  logic              master_en,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_start,
  output logic              tx_rdy,
  output logic              tx_done,
  output logic              rx_rdy,
  output logic              rx_done,
  output logic              busy,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NCS-1:0]    cs_n
);
  state_t r_state;
  logic r_cpha, r_sclk, r_mosi, r_busy, r_tx_done, r_rx_done;
  logic [DATA_W-1:0] r_tx, r_rx, r_rx_data;
  logic [NCS-1:0] r_cs_n;
  logic [EDGE_W-1:0] r_edge;
  logic w_tick, w_en, w_idle, w_shift, w_sample;
  logic [EDGE_W-1:0] w_edge;
  assign w_en     = spi_en & master_en;
  assign w_idle   = r_state == IDLE;
  assign w_edge   = (r_state == LEAD) ? EDGE_W'(1) : r_edge + 1'b1;
  assign w_shift  = r_cpha ? w_edge[0] : (!w_edge[0] && w_edge != EDGE_W'(N_EDGES));
  assign w_sample = r_cpha ^ w_edge[0];
  assign tx_rdy   = w_idle && w_en;
  assign rx_rdy   = w_idle;
  assign tx_done  = r_tx_done;
  assign rx_done  = r_rx_done;
  assign busy     = r_busy;
  assign rx_data  = r_rx_data;
  assign sclk     = r_sclk;
  assign mosi     = r_mosi;
  assign cs_n     = r_cs_n;
  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk,
    .rst,
    .i_clr(w_idle),
    .o_half_tick(w_tick)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cpha    <= 1'b0;
      r_sclk    <= 1'b0;
      r_mosi    <= 1'b0;
      r_busy    <= 1'b0;
      r_tx_done <= 1'b0;
      r_rx_done <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_cs_n    <= '1;
      r_edge    <= '0;
    end else begin
      r_tx_done <= 1'b0;
      r_rx_done <= 1'b0;
      if (w_idle) begin
        r_sclk <= cpol;
        r_cs_n <= '1;
        r_mosi <= (tx_start && w_en && !cpha) ? tx_data[DATA_W-1] : 1'b0;
        if (tx_start && w_en) begin
          r_state <= LEAD;
          r_busy  <= 1'b1;
          r_cpha  <= cpha;
          r_tx    <= cpha ? tx_data : {tx_data[DATA_W-2:0], 1'b0};
          r_cs_n  <= ~(NCS'(1) << cs_sel);
          r_edge  <= '0;
        end
      end else if (!w_en || r_state == DONE) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
        r_cs_n  <= '1;
        r_sclk  <= cpol;
        r_mosi  <= 1'b0;
      end else if (w_tick) begin
        if (r_state == TRAIL) begin
          r_state   <= DONE;
          r_rx_data <= r_rx;
          r_tx_done <= 1'b1;
          r_rx_done <= 1'b1;
        end else begin
          r_sclk  <= ~r_sclk;
          r_edge  <= w_edge;
          r_state <= (w_edge == EDGE_W'(N_EDGES)) ? TRAIL : XFER;
          if (w_shift) begin
            r_mosi <= r_tx[DATA_W-1];
            r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
          end
          if (w_sample) r_rx <= {r_rx[DATA_W-2:0], miso};
        end
      end
    end
  end
endmodule
